// File: rtl/mi_tester.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mi_tester: mi-protocol initiator that writes a seeded address pattern  |
// | over a region, reads it back and logs mismatches.                      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mi_tester #(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [7:0]    cfg_nburst,
  input  logic [6:0]    cfg_len,
  input  logic [31:0]   cfg_seed,
  output logic [AW-1:0] mi_addr,
  output logic [6:0]    mi_len,
  output logic          mi_rw,
  output logic          mi_valid,
  input  logic          mi_ready,
  output logic [31:0]   mi_wdata,
  input  logic          mi_wack,
  input  logic          mi_wlast,
  input  logic [31:0]   mi_rdata,
  input  logic          mi_rstb,
  input  logic          mi_rlast,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] err_addr,
  output logic [31:0]   err_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CMD  = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    nburst_q, nburst_d;
  logic [6:0]    len_q, len_d;
  logic [31:0]   seed_q, seed_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] burst_addr_q, burst_addr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [31:0]   err_data_q, err_data_d;

  logic [AW-1:0] w_step;
  logic [31:0]   w_rexp;

  assign w_step   = AW'({1'b0, len_q} + 8'd1);
  assign w_rexp   = seed_q + 32'(raddr_q);

  assign mi_valid = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
  assign mi_rw    = (state_q == S_RD_CMD);
  assign mi_addr  = burst_addr_q;
  assign mi_len   = len_q;
  assign mi_wdata = (state_q == S_WR_DATA) ? (seed_q + 32'(waddr_q)) : 32'd0;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign err_data = err_data_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    nburst_d     = nburst_q;
    len_d        = len_q;
    seed_d       = seed_q;
    burst_cnt_d  = burst_cnt_q;
    burst_addr_d = burst_addr_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    err_cnt_d    = err_cnt_q;
    err_addr_d   = err_addr_q;
    err_data_d   = err_data_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          base_d       = cfg_base;
          nburst_d     = cfg_nburst;
          len_d        = cfg_len;
          seed_d       = cfg_seed;
          burst_cnt_d  = cfg_nburst;
          burst_addr_d = cfg_base;
          err_cnt_d    = 16'd0;
          err_addr_d   = '0;
          err_data_d   = 32'd0;
          state_d      = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        if (mi_ready) begin
          waddr_d = burst_addr_q;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (mi_wack) begin
          waddr_d = waddr_q + AW'(1);
          if (mi_wlast) begin
            if (burst_cnt_q == 8'd0) begin
              // Read-back pass restarts from the first burst of the region
              burst_cnt_d  = nburst_q;
              burst_addr_d = base_q;
              state_d      = S_RD_CMD;
            end else begin
              burst_cnt_d  = burst_cnt_q - 8'd1;
              burst_addr_d = burst_addr_q + w_step;
              state_d      = S_WR_CMD;
            end
          end
        end
      end
      S_RD_CMD: begin
        if (mi_ready) begin
          raddr_d = burst_addr_q;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (mi_rstb) begin
          raddr_d = raddr_q + AW'(1);
          if (mi_rdata != w_rexp) begin
            // A zero count means no mismatch has been logged yet this test
            if (err_cnt_q == 16'd0) begin
              err_addr_d = raddr_q;
              err_data_d = mi_rdata;
            end
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (mi_rlast) begin
            if (burst_cnt_q == 8'd0) begin
              state_d = S_DONE;
            end else begin
              burst_cnt_d  = burst_cnt_q - 8'd1;
              burst_addr_d = burst_addr_q + w_step;
              state_d      = S_RD_CMD;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      nburst_q     <= 8'd0;
      len_q        <= 7'd0;
      seed_q       <= 32'd0;
      burst_cnt_q  <= 8'd0;
      burst_addr_q <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      err_cnt_q    <= 16'd0;
      err_addr_q   <= '0;
      err_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      nburst_q     <= nburst_d;
      len_q        <= len_d;
      seed_q       <= seed_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_addr_q <= burst_addr_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      err_cnt_q    <= err_cnt_d;
      err_addr_q   <= err_addr_d;
      err_data_q   <= err_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mi_tester.sv
`default_nettype none
// Bench for mi_tester: behavioural memory responder plus vector table and
// hand-written stall / mid-test reset sequences.
module tb_mi_tester;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [7:0]    cfg_nburst = 8'd0;
  logic [6:0]    cfg_len = 7'd0;
  logic [31:0]   cfg_seed = 32'd0;
  logic [AW-1:0] mi_addr;
  logic [6:0]    mi_len;
  logic          mi_rw;
  logic          mi_valid;
  logic          mi_ready = 1'b1;
  logic [31:0]   mi_wdata;
  logic          mi_wack = 1'b0;
  logic          mi_wlast = 1'b0;
  logic [31:0]   mi_rdata = 32'd0;
  logic          mi_rstb = 1'b0;
  logic          mi_rlast = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr;
  logic [31:0]   err_data;

  mi_tester #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_nburst(cfg_nburst), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
    .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack),
    .mi_wlast(mi_wlast), .mi_rdata(mi_rdata), .mi_rstb(mi_rstb),
    .mi_rlast(mi_rlast), .busy(busy), .done(done), .err_cnt(err_cnt),
    .err_addr(err_addr), .err_data(err_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [6:0]    len;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [7:0]    nb;
    logic [6:0]    len;
    logic [31:0]   seed;
    bit            flip;
    int            gap;
    logic [15:0]   ecnt;
    logic [AW-1:0] eaddr;
    logic [31:0]   edata;
  } vec_t;

  logic [31:0] mem [logic [AW-1:0]];
  cmd_t        cmds[$];
  bit          flip_en = 1'b0;
  int          gap = 0;
  int          rd_beats = 0;
  bit          in_data = 1'b0;
  int          viol = 0;
  int          nvec = 0;
  int          nerr = 0;

  // Memory responder: records commands, then serves beats after 'gap' idle cycles
  initial begin : responder
    cmd_t          c;
    logic [AW-1:0] a;
    logic [31:0]   d;
    forever begin
      @(negedge clk);
      if (mi_valid && mi_ready && !rst) begin
        c.rw = mi_rw; c.addr = mi_addr; c.len = mi_len;
        cmds.push_back(c);
        @(posedge clk); #1;
        in_data = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
        for (int i = 0; i <= int'(c.len); i++) begin
          a = c.addr + AW'(i);
          if (!c.rw) begin
            mi_wack = 1'b1; mi_wlast = (i == int'(c.len));
            mem[a] = mi_wdata;
          end else begin
            d = mem.exists(a) ? mem[a] : 32'd0;
            if (flip_en && (rd_beats == 1 || rd_beats == 4)) d = d ^ 32'd1;
            mi_rstb = 1'b1; mi_rlast = (i == int'(c.len)); mi_rdata = d;
            rd_beats++;
          end
          @(posedge clk); #1;
        end
        mi_wack = 1'b0; mi_wlast = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0;
        in_data = 1'b0;
      end
    end
  end

  always @(negedge clk) if (in_data && mi_valid) viol++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_test(input logic [AW-1:0] b, input logic [7:0] nb,
                            input logic [6:0] l, input logic [31:0] s);
    @(posedge clk); #1;
    cfg_base = b; cfg_nburst = nb; cfg_len = l; cfg_seed = s; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(output int ndone);
    ndone = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!busy) return;
    end
    $display("FAIL wait_done: timeout, busy still %0b", busy);
    nerr++;
  endtask

  task automatic run_vec(input vec_t v);
    int            nd, v0;
    bit            ok;
    logic [AW-1:0] ea;
    cmds.delete(); mem.delete();
    rd_beats = 0; flip_en = v.flip; gap = v.gap; v0 = viol;
    start_test(v.base, v.nb, v.len, v.seed);
    wait_done(nd);
    chk("done_once", 64'(nd), 64'd1);
    chk("err_cnt", 64'(err_cnt), 64'(v.ecnt));
    chk("err_addr", 64'(err_addr), 64'(v.eaddr));
    chk("err_data", 64'(err_data), 64'(v.edata));
    ok = (cmds.size() == 2 * (int'(v.nb) + 1));
    for (int k = 0; k < cmds.size(); k++) begin
      ea = v.base + AW'((k % (int'(v.nb) + 1)) * (int'(v.len) + 1));
      if (cmds[k].addr !== ea || cmds[k].len !== v.len || cmds[k].rw !== (k > int'(v.nb)))
        ok = 1'b0;
    end
    chk("cmd_seq", 64'(ok), 64'd1);
    ok = 1'b1;
    for (int w = 0; w < (int'(v.nb) + 1) * (int'(v.len) + 1); w++) begin
      ea = v.base + AW'(w);
      if (!mem.exists(ea) || mem[ea] !== v.seed + 32'(ea)) ok = 1'b0;
    end
    chk("mem_pattern", 64'(ok), 64'd1);
    chk("no_cmd_in_data", 64'(viol - v0), 64'd0);
  endtask

  initial begin : main
    vec_t vt[4];
    int   nd, v0;
    bit   ok;

    vt[0] = '{base:20'h00100, nb:8'd0, len:7'd3, seed:32'h0,        flip:1'b0, gap:0,
              ecnt:16'd0, eaddr:20'h0, edata:32'h0};
    vt[1] = '{base:20'h00040, nb:8'd2, len:7'd7, seed:32'h12345678, flip:1'b0, gap:3,
              ecnt:16'd0, eaddr:20'h0, edata:32'h0};
    vt[2] = '{base:20'hFFFFE, nb:8'd0, len:7'd3, seed:32'hDEAD0000, flip:1'b0, gap:1,
              ecnt:16'd0, eaddr:20'h0, edata:32'h0};
    vt[3] = '{base:20'h00000, nb:8'd0, len:7'd7, seed:32'hA5A50000, flip:1'b1, gap:2,
              ecnt:16'd2, eaddr:20'h1, edata:32'hA5A50000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(mi_valid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_err_data", 64'(err_data), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // Command stall: outputs must hold and a start pulse while busy is dropped
    cmds.delete(); mem.delete(); flip_en = 1'b0; gap = 0;
    mi_ready = 1'b0;
    start_test(20'h00200, 8'd0, 7'd3, 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(mi_valid === 1'b1 && mi_addr === 20'h00200 && mi_len === 7'd3 && mi_rw === 1'b0))
        ok = 1'b0;
      if (i == 4) begin cfg_base = 20'h00300; cfg_start = 1'b1; end
      if (i == 5) cfg_start = 1'b0;
    end
    chk("stall_stable", 64'(ok), 64'd1);
    @(posedge clk); #1 mi_ready = 1'b1;
    wait_done(nd);
    chk("stall_done", 64'(nd), 64'd1);
    chk("stall_cmds", 64'(cmds.size()), 64'd2);
    chk("stall_addr", 64'(cmds[0].addr), 64'h200);
    repeat (3) @(negedge clk);
    chk("stall_no_restart", 64'(busy), 64'd0);

    // Reset during RD_DATA after two mismatches; cfg_start in the same cycle
    cmds.delete(); mem.delete(); rd_beats = 0; flip_en = 1'b1; gap = 2;
    start_test(20'h00010, 8'd0, 7'd7, 32'h0);
    for (int c = 0; c < 500 && rd_beats < 6; c++) @(negedge clk);
    chk("pre_rst_errs", 64'(err_cnt), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1; cfg_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_err_cnt", 64'(err_cnt), 64'd0);
    v0 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mi_valid) v0++;
    end
    chk("abort_no_valid", 64'(v0), 64'd0);
    run_vec('{base:20'h00020, nb:8'd1, len:7'd3, seed:32'h0BADF00D, flip:1'b0, gap:0,
              ecnt:16'd0, eaddr:20'h0, edata:32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mi_tester.md
MI_TESTER -- requirements
Module: mi_tester

Interface
REQ-001 Parameter AW, default 20, is the word-address width of mi_addr and of every address field.
REQ-002 clk  input  1  clock; all logic is rising-edge.
REQ-003 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-004 cfg_start  input  1  single-cycle start pulse; ignored while busy.
REQ-005 cfg_base  input  AW  first word address of the test.
REQ-006 cfg_nburst  input  8  number of bursts minus one.
REQ-007 cfg_len  input  7  words per burst minus one; driven unchanged on mi_len.
REQ-008 cfg_seed  input  32  pattern seed.
REQ-009 mi_addr  output  AW  command burst start address.
REQ-010 mi_len  output  7  command burst length minus one.
REQ-011 mi_rw  output  1  1=read, 0=write.
REQ-012 mi_valid  output  1  command valid.
REQ-013 mi_ready  input  1  command accepted when mi_valid and mi_ready are both high.
REQ-014 mi_wdata  output  32  write data for the current beat.
REQ-015 mi_wack  input  1  responder consumed mi_wdata this cycle.
REQ-016 mi_wlast  input  1  marks the final wack of a burst.
REQ-017 mi_rdata  input  32  read data, valid only when mi_rstb is high.
REQ-018 mi_rstb  input  1  read data strobe.
REQ-019 mi_rlast  input  1  marks the final rstb of a burst.
REQ-020 busy  output  1  test in progress.
REQ-021 done  output  1  one-cycle pulse at test completion.
REQ-022 err_cnt  output  16  mismatch count, saturating.
REQ-023 err_addr  output  AW  address of the first mismatch.
REQ-024 err_data  output  32  read data of the first mismatch.

Function
REQ-025 The block SHALL be the initiator of the mi protocol: it writes a pattern over the region, then reads the region back and checks it.
REQ-026 FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE.
- IDLE->WR_CMD on cfg_start.
- WR_CMD->WR_DATA on command accept.
- WR_DATA->WR_CMD on wack&wlast when bursts remain, else ->RD_CMD.
- RD_CMD->RD_DATA on command accept.
- RD_DATA->RD_CMD on rstb&rlast when bursts remain, else ->DONE.
- DONE->IDLE after one cycle.
REQ-027 On cfg_start in IDLE, the block SHALL latch cfg_base, cfg_nburst, cfg_len and cfg_seed; clear err_cnt, err_addr and err_data; and load the burst counter.
REQ-028 mi_valid SHALL be high only in WR_CMD and RD_CMD; mi_rw SHALL be 0 in WR_CMD and 1 in RD_CMD.
REQ-029 mi_addr, mi_len and mi_rw SHALL be stable while mi_valid is high.
REQ-030 Each burst SHALL transfer cfg_len+1 words.
REQ-031 Burst k SHALL start at address base + k*(cfg_len+1), computed modulo 2^AW (address wrap permitted).
REQ-032 Pattern: the word at address A SHALL be cfg_seed + zero-extended A, modulo 2^32.
REQ-033 The write address counter SHALL be loaded with the burst address on command accept and SHALL increment on each mi_wack.
REQ-034 mi_wdata SHALL combinationally equal the pattern of the write address counter whenever in WR_DATA.
REQ-035 The read address counter SHALL be loaded with the burst address on command accept and SHALL increment on each mi_rstb.
REQ-036 Each mi_rstb SHALL compare mi_rdata against the pattern of the read address counter.
REQ-037 On a mismatch, err_cnt SHALL increment, holding at 16'hFFFF.
REQ-038 err_addr and err_data SHALL capture only the first mismatch of a test.
REQ-039 The burst counter SHALL decrement at the end of each write burst and at the end of each read burst; it SHALL reload from the latched cfg_nburst when entering RD_CMD.
REQ-040 mi_wack, mi_rstb, mi_wlast and mi_rlast SHALL be ignored in every state other than their own data state.
REQ-041 busy SHALL be high in every state except IDLE.
REQ-042 done SHALL pulse in DONE; err_cnt, err_addr and err_data SHALL hold their values until the next accepted cfg_start.
REQ-043 Read-back results SHALL not depend on the number of cycles between command accept and the first mi_wack or mi_rstb.

Reset
REQ-044 rst SHALL force IDLE, mi_valid=0, busy=0, done=0, err_cnt=0, err_addr=0, err_data=0, and both address counters to 0.
REQ-045 rst asserted mid-test SHALL abort the test immediately, with no further mi_valid until a new cfg_start.
REQ-046 cfg_start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-047 Against a mem_sim responder: base=0x100, nburst=0, len=3, seed=0 -> one write then one read of 4 words at 0x100..0x103; data 0x100..0x103; err_cnt=0; done pulses once.
REQ-048 nburst=2, len=7, base=0x40 -> write commands at 0x40, 0x48, 0x50, then reads at the same addresses; no command while in a data state.
REQ-049 AW=20, base=0xFFFFE, len=3, nburst=0 -> addresses wrap to 0x00000 and 0x00001; err_cnt=0.
REQ-050 The bench flips bit 0 of mi_rdata on the 2nd and 5th read words (base=0, seed=0xA5A50000, len=7) -> err_cnt=2, err_addr=1, err_data=0xA5A50000.
REQ-051 Hold mi_ready low for 10 cycles -> mi_valid, mi_addr and mi_len stay stable; cfg_start pulses while busy are ignored.
REQ-052 Assert rst during RD_DATA -> the next cycle shows busy=0 and err_cnt=0; a fresh cfg_start then completes normally.
